piso8_tx_ctrl: RTL

PISO8_TX_CTRL -- requirements
Module: piso8_tx_ctrl

---
 rtl/piso8_tx_pkg.sv | 13 +
 rtl/bit_timer.sv | 29 ++
 rtl/piso8_tx_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/piso8_tx_pkg.sv
// Shared types and constants for the PISO8 transmit controller.
// No logic; combinational constants only.
// No flow control.
package piso8_tx_pkg;
    localparam int NBITS     = 8;
    localparam int DIV_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;
endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: counts 0..DIV-1 while run is high, clears otherwise.
// tc is combinational in the last cycle of each bit period.
// No backpressure; run low forces the count back to zero on the next edge.
module bit_timer
    import piso8_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic run,
    output logic tc
);
    localparam logic [DIV_CNT_W-1:0] TC_VAL = DIV_CNT_W'(DIV - 1);

    logic [DIV_CNT_W-1:0] div_cnt;

    assign tc = run && (div_cnt == TC_VAL);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            div_cnt <= '0;
        end else if (!run || (div_cnt == TC_VAL)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/piso8_tx_ctrl.sv
// Drives an external CE-gated PISO8 to send one byte MSB first, DIV cycles per bit.
// Frame = 1 LOAD cycle + 8*DIV SHIFT cycles after the accepting edge.
// READY only in IDLE with ABORT low; VALID/DATA ignored while a frame is running.
module piso8_tx_ctrl
    import piso8_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    input  logic       ABORT,
    output logic [7:0] PISO_PI,
    output logic       PISO_LOAD,
    output logic       PISO_CE,
    output logic       PISO_SI,
    output logic       FRAME,
    output logic       DONE
);
    localparam logic [2:0] LAST_BIT = 3'(NBITS - 1);

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic [2:0] bit_cnt;
    logic [7:0] pi_q;
    logic       accept;
    logic       tmr_run;
    logic       tmr_tc;

    // An abort also stops the timer so no terminal count can fire this cycle.
    assign tmr_run = (state == SHIFT) && !ABORT;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .core_clk (CLK),
        .arst_n   (RESETN),
        .run      (tmr_run),
        .tc       (tmr_tc)
    );

    assign PISO_PI = pi_q;
    assign PISO_SI = 1'b0;

    always_comb begin
        state_nxt = state;
        READY     = 1'b0;
        PISO_LOAD = 1'b0;
        PISO_CE   = 1'b0;
        FRAME     = 1'b0;
        DONE      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by RESETN so READY is low throughout reset.
                READY  = !ABORT && RESETN;
                accept = VALID && READY;
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                PISO_LOAD = 1'b1;
                PISO_CE   = 1'b1;
                state_nxt = ABORT ? IDLE : SHIFT;
            end
            SHIFT: begin
                FRAME = 1'b1;
                if (ABORT) begin
                    state_nxt = IDLE;
                end else if (tmr_tc) begin
                    if (bit_cnt == LAST_BIT) begin
                        DONE      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        PISO_CE = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            bit_cnt <= '0;
            pi_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pi_q <= DATA;
            end
            if (state != SHIFT) begin
                bit_cnt <= '0;
            end else if (PISO_CE) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule
